// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the UART program loader.
// The CHK state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int         ADDR_W_DEF     = 11;
    localparam int         MEM_WORDS_DEF  = 2048;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] MAGIC          = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK    = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Shifts received bytes MSB-first into a 32-bit word and counts bytes 0..3.
// word_done/word_next are combinational so the caller can register the write.
module loader_word_asm
    import loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word_next
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign word_next = {shift_q, byte_in};
    assign word_done = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en) begin
            shift_q <= {shift_q[15:0], byte_in};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: parses A5/LEN/data frames and writes words to instruction RAM.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    state_t            state;
    logic [7:0]        len_hi_q;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        chk;
`endif

    logic        xfer;
    logic        byte_en;
    logic        start;
    logic [15:0] len_w;
    logic        word_done;
    logic [31:0] word_next;

    assign xfer    = rx_valid && rx_ready;
    assign byte_en = xfer && (state == DATA);
    // Magic only restarts from a resting state; mid-frame it is ordinary data.
    assign start   = xfer && (rx_data == MAGIC) &&
                     (state == IDLE || state == DONE || state == ERR);
    assign len_w   = {len_hi_q, rx_data};

    loader_word_asm u_word_asm (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (start),
        .byte_en   (byte_en),
        .byte_in   (rx_data),
        .word_done (word_done),
        .word_next (word_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rx_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            len_hi_q  <= '0;
            word_idx  <= '0;
            last_idx  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk       <= '0;
`endif
        end else begin
            // The write cycle stalls the receiver, giving the FSM one cycle to advance the index.
            mem_we   <= word_done;
            rx_ready <= !word_done;
            if (word_done) begin
                mem_addr  <= word_idx;
                mem_wdata <= word_next;
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN_HI;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        word_idx  <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi_q <= rx_data;
                        state    <= LEN_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk      <= rx_data;
`endif
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        word_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk      <= chk ^ rx_data;
`endif
                        if (len_w == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else if ({16'd0, len_w} > 32'(MEM_WORDS)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else begin
                            state    <= DATA;
                            last_idx <= ADDR_W'(len_w - 16'd1);
                        end
                    end
                end
                DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (byte_en) chk <= chk ^ rx_data;
`endif
                    if (mem_we) begin
                        word_idx <= word_idx + ADDR_W'(1);
                        if (word_idx == last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        if (rx_data == chk) begin
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN
// so checksum bytes are sent only when the feature is built in.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int ADDR_W    = 11;
    localparam int MEM_WORDS = 2048;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    prog_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #31 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction RAM model plus write-strobe monitors.
    logic [31:0] ram [0:MEM_WORDS-1];
    int          n_writes = 0;
    int          we_long  = 0;
    logic        prev_we  = 1'b0;

    always @(posedge CLK) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            n_writes      <= n_writes + 1;
            if (prev_we) we_long <= we_long + 1;
        end
        prev_we <= mem_we;
    end

    logic [31:0] fw [0:3];

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        t = 0;
        while (!rx_ready && t < 8) begin
            @(negedge CLK);
            t++;
        end
        if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = MAGIC;   // junk on the idle bus must be ignored
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                              input int nw, input int maxgap, input logic corrupt);
        logic [7:0]  ck;
        logic [7:0]  b;
        logic [31:0] w;
        send_byte(MAGIC, pick_gap(maxgap));
        send_byte(hi, pick_gap(maxgap));
        send_byte(lo, pick_gap(maxgap));
        ck = hi ^ lo;
        for (int i = 0; i < nw; i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                b  = w[31-8*k -: 8];
                ck = ck ^ b;
                send_byte(b, pick_gap(maxgap));
            end
            check($sformatf("%s_we%0d", tag, i), {31'd0, mem_we}, 32'd1);
            check($sformatf("%s_addr%0d", tag, i), 32'(mem_addr), 32'(i));
            check($sformatf("%s_data%0d", tag, i), mem_wdata, w);
            check($sformatf("%s_rdy%0d", tag, i), {31'd0, rx_ready}, 32'd0);
            check($sformatf("%s_hold%0d", tag, i), {31'd0, cpu_hold}, 32'd1);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(corrupt ? ~ck : ck, pick_gap(maxgap));
`else
        if (corrupt) check($sformatf("%s_corrupt_unsupported", tag), 32'd0, 32'd1);
`endif
    endtask

    task automatic expect_done(input string tag, input int nw);
`ifndef PROG_LOADER_CHECKSUM_EN
        if (nw > 0) begin
            @(posedge CLK);
            #1;
        end
`endif
        check({tag, "_done"}, {31'd0, load_done}, 32'd1);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_err"},  {31'd0, load_err}, 32'd0);
    endtask

    initial begin
        #(62 * 60000);
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset values
        #5 RST = 1'b1;
        #5;
        check("rst_rx_ready",  {31'd0, rx_ready},  32'd1);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  32'(mem_addr),      32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        check("rst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err",  {31'd0, load_err},  32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_no_write", 32'(n_writes), 32'd0);

        // Two-word frame
        fw[0] = 32'h2000_0001;
        fw[1] = 32'h1008_0000;
        base = n_writes;
        send_frame("a", 8'h00, 8'h02, 2, 0, 1'b0);
        expect_done("a", 2);
        check("a_ram0", ram[0], 32'h2000_0001);
        check("a_ram1", ram[1], 32'h1008_0000);
        check("a_nwr", 32'(n_writes - base), 32'd2);

        // Zero-length frame
        base = n_writes;
        send_byte(MAGIC, 0);
        check("z_done_clr", {31'd0, load_done}, 32'd0);
        check("z_hold_set", {31'd0, cpu_hold},  32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        expect_done("z", 0);
        repeat (2) @(negedge CLK);
        check("z_nwr", 32'(n_writes - base), 32'd0);

        // Oversize length (2049) errors; a stray byte does not recover; a good frame does
        base = n_writes;
        send_byte(MAGIC, 0);
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        check("big_err",  {31'd0, load_err},  32'd1);
        check("big_hold", {31'd0, cpu_hold},  32'd1);
        check("big_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h12, 3);
        check("big_stay_err", {31'd0, load_err}, 32'd1);
        check("big_nwr", 32'(n_writes - base), 32'd0);
        send_frame("rec", 8'h00, 8'h02, 2, 0, 1'b0);
        expect_done("rec", 2);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum: words land in RAM but the load is rejected
        base = n_writes;
        send_frame("ck", 8'h00, 8'h02, 2, 0, 1'b1);
        check("ck_err",  {31'd0, load_err},  32'd1);
        check("ck_hold", {31'd0, cpu_hold},  32'd1);
        check("ck_done", {31'd0, load_done}, 32'd0);
        check("ck_nwr",  32'(n_writes - base), 32'd2);
`endif

        // Exactly MEM_WORDS is accepted; abort with reset after the first word
        fw[0] = 32'hCAFE_F00D;
        send_byte(MAGIC, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        check("max_err",  {31'd0, load_err}, 32'd0);
        check("max_hold", {31'd0, cpu_hold}, 32'd1);
        for (int k = 0; k < 4; k++) send_byte(fw[0][31-8*k -: 8], 0);
        check("max_we",   {31'd0, mem_we}, 32'd1);
        check("max_data", mem_wdata, 32'hCAFE_F00D);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Reset mid-word: partial word dropped, earlier word kept
        fw[0] = 32'hDEAD_BEEF;
        base = n_writes;
        send_byte(MAGIC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 4; k++) send_byte(fw[0][31-8*k -: 8], 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, rx_ready},  32'd1);
        check("mid_rst_we",    {31'd0, mem_we},    32'd0);
        check("mid_rst_addr",  32'(mem_addr),      32'd0);
        check("mid_rst_wdata", mem_wdata,          32'd0);
        check("mid_rst_hold",  {31'd0, cpu_hold},  32'd1);
        check("mid_rst_done",  {31'd0, load_done}, 32'd0);
        check("mid_rst_err",   {31'd0, load_err},  32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_rst_nwr",  32'(n_writes - base), 32'd1);
        check("mid_rst_ram0", ram[0], 32'hDEAD_BEEF);
        fw[0] = 32'h2000_0001;
        fw[1] = 32'h1008_0000;
        send_frame("retx", 8'h00, 8'h02, 2, 0, 1'b0);
        expect_done("retx", 2);
        check("retx_ram0", ram[0], 32'h2000_0001);
        check("retx_ram1", ram[1], 32'h1008_0000);

        // Same three-word frame, gap-free then with random gaps; first data byte is the magic value
        fw[0] = 32'hA511_2233;
        fw[1] = 32'h4455_6677;
        fw[2] = 32'h8899_AABB;
        for (int pass = 0; pass < 2; pass++) begin
            base = n_writes;
            send_frame(pass == 0 ? "nogap" : "gap", 8'h00, 8'h03, 3, pass * 20, 1'b0);
            expect_done(pass == 0 ? "nogap" : "gap", 3);
            check($sformatf("g%0d_ram0", pass), ram[0], 32'hA511_2233);
            check($sformatf("g%0d_ram1", pass), ram[1], 32'h4455_6677);
            check($sformatf("g%0d_ram2", pass), ram[2], 32'h8899_AABB);
            check($sformatf("g%0d_nwr", pass), 32'(n_writes - base), 32'd3);
        end

        check("we_single_cycle", 32'(we_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
